// File: rtl/poly_envelope_generator_pkg.sv
// Shared definitions for the polyphonic envelope generator: one-hot voice
// state encoding and parameter defaults.
package poly_envelope_generator_pkg;

    localparam int VOICES_DEF  = 4;
    localparam int LEVEL_W_DEF = 18;
    localparam int RATE_W_DEF  = 32;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ATTACK  = 5'b00010,
        ST_DECAY   = 5'b00100,
        ST_SUSTAIN = 5'b01000,
        ST_RELEASE = 5'b10000
    } env_state_e;

endpackage

// File: rtl/poly_envelope_generator_if.sv
// Note events, shared envelope settings and per-voice outputs of the
// envelope generator, grouped as one bundle.
interface poly_envelope_generator_if
    import poly_envelope_generator_pkg::*;
#(
    parameter int VOICES  = VOICES_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF,
    parameter int RATE_W  = RATE_W_DEF
);
    logic [VOICES-1:0]         note_on;
    logic [VOICES-1:0]         note_off;
    logic [LEVEL_W-1:0]        attack_level;
    logic [LEVEL_W-1:0]        sustain_level;
    logic [LEVEL_W-1:0]        release_level;
    logic [RATE_W-1:0]         attack_rate;
    logic [RATE_W-1:0]         decay_rate;
    logic [RATE_W-1:0]         release_rate;
    logic [LEVEL_W-1:0]        step;
    logic [VOICES*LEVEL_W-1:0] level_out;
    logic [VOICES-1:0]         busy;
    logic [VOICES-1:0]         done;

    modport master (
        output note_on, note_off,
        output attack_level, sustain_level, release_level,
        output attack_rate, decay_rate, release_rate, step,
        input  level_out, busy, done
    );

    modport slave (
        input  note_on, note_off,
        input  attack_level, sustain_level, release_level,
        input  attack_rate, decay_rate, release_rate, step,
        output level_out, busy, done
    );
endinterface

// File: rtl/poly_envelope_generator_env_voice.sv
// One envelope voice: ADSR sequencer with a rate tick counter and a level
// register that steps toward the current phase target without overshoot.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no note; level held, counter held at 0
// ST_ATTACK  | stepping toward attack_level at attack_rate
// ST_DECAY   | stepping toward sustain_level at decay_rate
// ST_SUSTAIN | level frozen until note_off, counter held at 0
// ST_RELEASE | stepping toward release_level at release_rate; note_on retriggers
module env_voice
    import poly_envelope_generator_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF,
    parameter int RATE_W  = RATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               note_on,
    input  logic               note_off,
    input  logic [LEVEL_W-1:0] attack_level,
    input  logic [LEVEL_W-1:0] sustain_level,
    input  logic [LEVEL_W-1:0] release_level,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [RATE_W-1:0]  release_rate,
    input  logic [LEVEL_W-1:0] step,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               done
);

    env_state_e         state_q, state_d, exit_state;
    logic [RATE_W-1:0]  cnt_q, cnt_d, rate;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] target, step_eff, diff, stepped;
    logic               up, at_target, tick;
    logic               busy_q, done_q;

    always_comb begin
        target     = '0;
        rate       = '0;
        exit_state = ST_IDLE;
        case (state_q)
            ST_ATTACK: begin
                target     = attack_level;
                rate       = attack_rate;
                exit_state = ST_DECAY;
            end
            ST_DECAY: begin
                target     = sustain_level;
                rate       = decay_rate;
                exit_state = ST_SUSTAIN;
            end
            ST_RELEASE: begin
                target     = release_level;
                rate       = release_rate;
                exit_state = ST_IDLE;
            end
            default: ;
        endcase
    end

    // Distance is measured before stepping, so the add/subtract can never wrap.
    assign step_eff  = (step == '0) ? LEVEL_W'(1) : step;
    assign up        = target > level_q;
    assign diff      = up ? (target - level_q) : (level_q - target);
    assign stepped   = (diff <= step_eff) ? target
                     : (up ? (level_q + step_eff) : (level_q - step_eff));
    assign at_target = (level_q == target);
    // >= rather than == so a live rate reduction below the count fires at once.
    assign tick      = (cnt_q >= rate);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (note_on && !note_off) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_SUSTAIN: begin
                cnt_d = '0;
                if (note_off) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_ATTACK, ST_DECAY, ST_RELEASE: begin
                if (state_q != ST_RELEASE && note_off) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (state_q == ST_RELEASE && note_on && !note_off) begin
                    state_d = ST_ATTACK;
                    cnt_d   = '0;
                end else if (at_target) begin
                    state_d = exit_state;
                    cnt_d   = '0;
                end else if (tick) begin
                    level_d = stepped;
                    cnt_d   = '0;
                    if (stepped == target) begin
                        state_d = exit_state;
                    end
                end else begin
                    cnt_d = cnt_q + RATE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_q == ST_RELEASE) && (state_d == ST_IDLE);
        end
    end

    assign level = level_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: rtl/poly_envelope_generator.sv
// Polyphonic envelope generator: VOICES independent env_voice instances
// sharing one set of envelope settings; the top only slices buses.
module poly_envelope_generator
    import poly_envelope_generator_pkg::*;
#(
    parameter int VOICES  = VOICES_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF,
    parameter int RATE_W  = RATE_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_b,
    poly_envelope_generator_if.slave  bus
);

    logic [VOICES*LEVEL_W-1:0] level_w;
    logic [VOICES-1:0]         busy_w;
    logic [VOICES-1:0]         done_w;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        env_voice #(
            .LEVEL_W (LEVEL_W),
            .RATE_W  (RATE_W)
        ) u_voice (
            .clk           (clk),
            .rst_b         (rst_b),
            .note_on       (bus.note_on[v]),
            .note_off      (bus.note_off[v]),
            .attack_level  (bus.attack_level),
            .sustain_level (bus.sustain_level),
            .release_level (bus.release_level),
            .attack_rate   (bus.attack_rate),
            .decay_rate    (bus.decay_rate),
            .release_rate  (bus.release_rate),
            .step          (bus.step),
            .level         (level_w[v*LEVEL_W +: LEVEL_W]),
            .busy          (busy_w[v]),
            .done          (done_w[v])
        );
    end

    assign bus.level_out = level_w;
    assign bus.busy      = busy_w;
    assign bus.done      = done_w;

endmodule

// File: tb/tb_poly_envelope_generator.sv
// Scoreboard bench for poly_envelope_generator: directed note sequences push
// per-cycle expected voice outputs; a negedge monitor pops and compares them.
module tb_poly_envelope_generator;
    import poly_envelope_generator_pkg::*;

    localparam int VOICES  = 4;
    localparam int LEVEL_W = 18;
    localparam int RATE_W  = 32;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    poly_envelope_generator_if #(
        .VOICES(VOICES), .LEVEL_W(LEVEL_W), .RATE_W(RATE_W)
    ) bus ();

    poly_envelope_generator #(
        .VOICES(VOICES), .LEVEL_W(LEVEL_W), .RATE_W(RATE_W)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    typedef struct {
        int    cyc;
        int    v;
        int    lvl;
        logic  busy;
        logic  done;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: after edge k the outputs seen at the following negedge belong to cycle k.
    exp_t m_e;
    int   m_lvl;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e   = sb.pop_front();
            m_lvl = int'(bus.level_out[m_e.v*LEVEL_W +: LEVEL_W]);
            n_cmp++;
            if (m_lvl != m_e.lvl || bus.busy[m_e.v] !== m_e.busy || bus.done[m_e.v] !== m_e.done) begin
                n_err++;
                $display("FAIL %s v%0d cyc%0d: got lvl=%0d busy=%b done=%b, want lvl=%0d busy=%b done=%b",
                         m_e.tag, m_e.v, cyc, m_lvl, bus.busy[m_e.v], bus.done[m_e.v],
                         m_e.lvl, m_e.busy, m_e.done);
            end
        end
    end

    function automatic void exp_at(int d, int v, int lvl, logic b, logic dn, string tag);
        exp_t e;
        int   i;
        e = '{cyc + d, v, lvl, b, dn, tag};
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > e.cyc) i--;
        sb.insert(i, e);
    endfunction

    // n consecutive cycles starting at offset d0, level lvl0 changing by inc each cycle.
    function automatic void exp_run(int v, int d0, int n, int lvl0, int inc, logic b, string tag);
        for (int k = 0; k < n; k++) exp_at(d0 + k, v, lvl0 + k*inc, b, 1'b0, tag);
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_zero(string tag);
        n_cmp++;
        if (bus.level_out !== '0 || bus.busy !== '0 || bus.done !== '0) begin
            n_err++;
            $display("FAIL %s: got level_out=%h busy=%b done=%b, want all zero",
                     tag, bus.level_out, bus.busy, bus.done);
        end
    endtask

    initial begin
        bus.note_on       = '0;
        bus.note_off      = '0;
        bus.attack_level  = 18'd4;
        bus.sustain_level = 18'd2;
        bus.release_level = 18'd0;
        bus.attack_rate   = '0;
        bus.decay_rate    = '0;
        bus.release_rate  = '0;
        bus.step          = 18'd1;

        tick(2);
        check_zero("reset_state");
        rst_b = 1'b1;
        for (int v = 0; v < VOICES; v++) exp_run(v, 1, 2, 0, 0, 1'b0, "post_reset");
        tick(3);

        // Attack/decay into sustain on voices 0 and 1; 2 and 3 stay idle.
        for (int v = 0; v < 2; v++) begin
            exp_at(1, v, 0, 1'b1, 1'b0, "attack_entry");
            exp_run(v, 2, 4, 1, 1, 1'b1, "attack_ramp");
            exp_run(v, 6, 2, 3, -1, 1'b1, "decay_ramp");
            exp_run(v, 8, 2, 2, 0, 1'b1, "sustain_hold");
        end
        for (int v = 2; v < 4; v++) exp_run(v, 1, 9, 0, 0, 1'b0, "idle_indep");
        bus.note_on = 4'b0011;
        tick(1);
        bus.note_on = '0;
        tick(10);

        // Release voice 1 to 0 with a one-cycle done pulse; voice 0 untouched.
        exp_at(1, 1, 2, 1'b1, 1'b0, "release_entry");
        exp_at(2, 1, 1, 1'b1, 1'b0, "release_step");
        exp_at(3, 1, 0, 1'b0, 1'b1, "release_done");
        exp_run(1, 4, 2, 0, 0, 1'b0, "done_one_cycle");
        exp_run(0, 1, 5, 2, 0, 1'b1, "sustain_indep");
        bus.note_off = 4'b0010;
        tick(1);
        bus.note_off = '0;
        tick(6);

        // Step 3 toward 10 clamps at 10, then decay clamps down at 2.
        bus.step         = 18'd3;
        bus.attack_level = 18'd10;
        exp_at(1, 1, 0, 1'b1, 1'b0, "clamp_entry");
        exp_at(2, 1, 3, 1'b1, 1'b0, "clamp_3");
        exp_at(3, 1, 6, 1'b1, 1'b0, "clamp_6");
        exp_at(4, 1, 9, 1'b1, 1'b0, "clamp_9");
        exp_at(5, 1, 10, 1'b1, 1'b0, "clamp_10");
        exp_at(6, 1, 7, 1'b1, 1'b0, "clamp_dec7");
        exp_at(7, 1, 4, 1'b1, 1'b0, "clamp_dec4");
        exp_run(1, 8, 2, 2, 0, 1'b1, "clamp_dec2");
        exp_run(0, 1, 9, 2, 0, 1'b1, "sustain_live_tgt");
        bus.note_on = 4'b0010;
        tick(1);
        bus.note_on = '0;
        tick(10);
        bus.step = 18'd1;

        // Voice 2 to sustain at 8.
        bus.attack_level  = 18'd8;
        bus.sustain_level = 18'd8;
        exp_at(1, 2, 0, 1'b1, 1'b0, "v2_attack_entry");
        exp_run(2, 2, 8, 1, 1, 1'b1, "v2_attack_ramp");
        exp_run(2, 10, 2, 8, 0, 1'b1, "v2_decay_at_tgt");
        bus.note_on = 4'b0100;
        tick(1);
        bus.note_on = '0;
        tick(11);

        // Release to 5, retrigger attack from 5, then note_on+note_off in decay forces release.
        bus.sustain_level = 18'd2;
        bus.decay_rate    = 32'd3;
        exp_at(1, 2, 8, 1'b1, 1'b0, "rel_entry");
        exp_run(2, 2, 3, 7, -1, 1'b1, "rel_ramp");
        exp_run(2, 5, 4, 5, 1, 1'b1, "retrigger_ramp");
        exp_at(9, 2, 8, 1'b1, 1'b0, "decay_wait");
        exp_at(10, 2, 8, 1'b1, 1'b0, "prio_release");
        exp_run(2, 11, 7, 7, -1, 1'b1, "prio_rel_ramp");
        exp_at(18, 2, 0, 1'b0, 1'b1, "prio_rel_done");
        exp_at(19, 2, 0, 1'b0, 1'b0, "prio_idle");
        bus.note_off = 4'b0100;
        tick(1);
        bus.note_off = '0;
        tick(3);
        bus.note_on = 4'b0100;
        tick(1);
        bus.note_on = '0;
        tick(4);
        bus.note_on  = 4'b0100;
        bus.note_off = 4'b0100;
        tick(1);
        bus.note_on  = '0;
        bus.note_off = '0;
        tick(10);

        // Rate divider: attack_rate=3 steps every 4th cycle.
        bus.attack_rate   = 32'd3;
        bus.attack_level  = 18'd2;
        bus.sustain_level = 18'd2;
        exp_run(3, 1, 4, 0, 0, 1'b1, "rate_wait");
        exp_run(3, 5, 4, 1, 0, 1'b1, "rate_step1");
        exp_run(3, 9, 3, 2, 0, 1'b1, "rate_step2");
        exp_run(0, 1, 5, 2, 0, 1'b1, "rate_indep_v0");
        exp_run(2, 1, 5, 0, 0, 1'b0, "rate_indep_v2");
        bus.note_on = 4'b1000;
        tick(1);
        bus.note_on = '0;
        tick(12);

        // Reset mid-attack on voice 2 while voice 3 sustains.
        bus.attack_rate   = '0;
        bus.attack_level  = 18'd10;
        exp_run(2, 1, 3, 0, 1, 1'b1, "pre_reset_attack");
        exp_at(3, 3, 2, 1'b1, 1'b0, "pre_reset_sustain");
        bus.note_on = 4'b0100;
        tick(1);
        bus.note_on = '0;
        tick(3);
        #2;
        rst_b = 1'b0;
        #1;
        check_zero("async_reset");
        tick(2);
        check_zero("reset_held");
        rst_b = 1'b1;
        for (int v = 0; v < VOICES; v++) exp_run(v, 1, 4, 0, 0, 1'b0, "after_reset_idle");
        tick(5);

        for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_envelope_generator.md
POLY_ENVELOPE_GENERATOR -- requirements
Module: poly_envelope_generator

Interface
REQ-001 SHALL have parameter VOICES, default 4, number of independent envelope voices (1..16).
REQ-002 SHALL have parameter LEVEL_W, default 18, width of level, step and target values.
REQ-003 SHALL have parameter RATE_W, default 32, width of rate (tick-divider) values.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_b  input  1  asynchronous, active-low reset.
REQ-006 note_on  input  VOICES  per-voice note start, level-sensitive, sampled each cycle.
REQ-007 note_off  input  VOICES  per-voice note release, level-sensitive, sampled each cycle.
REQ-008 attack_level, sustain_level, release_level  input  LEVEL_W each  shared targets: attack peak, sustain hold, release floor.
REQ-009 attack_rate, decay_rate, release_rate  input  RATE_W each  shared phase rates: cycles per step minus one.
REQ-010 step  input  LEVEL_W  shared level increment per update; 0 is treated as 1.
REQ-011 level_out  output  VOICES*LEVEL_W  voice v level at bits [v*LEVEL_W +: LEVEL_W].
REQ-012 busy  output  VOICES  voice not in IDLE.
REQ-013 done  output  VOICES  one-cycle pulse when a voice completes release.

Function
REQ-014 Each voice SHALL run an independent FSM with states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, plus a RATE_W tick counter and a LEVEL_W level register.
REQ-015 Transitions: IDLE->ATTACK on note_on=1 and note_off=0; ATTACK->DECAY when level==attack_level; DECAY->SUSTAIN when level==sustain_level; RELEASE->IDLE when level==release_level.
REQ-016 note_off=1 in ATTACK, DECAY or SUSTAIN SHALL force RELEASE on the next edge, overriding all other transitions, including a simultaneous note_on.
REQ-017 note_on=1 with note_off=0 in RELEASE SHALL retrigger ATTACK from the current level; this is a new feature.
REQ-018 note_on in ATTACK, DECAY or SUSTAIN SHALL be ignored.
REQ-019 The phase target SHALL be attack_level in ATTACK, sustain_level in DECAY and release_level in RELEASE, with the matching rate.
REQ-020 In ATTACK, DECAY and RELEASE the counter SHALL increment each cycle.
REQ-021 When the counter equals the rate, the level SHALL move one step toward the target and the counter SHALL clear.
REQ-022 The counter SHALL clear on every state change and be held at 0 in IDLE and SUSTAIN.
REQ-023 Stepping toward the target SHALL clamp exactly at the target and never overshoot.
REQ-024 Level arithmetic SHALL never wrap.
REQ-025 Direction SHALL be chosen per update from the sign of target-level, so a target below the current level moves downward in any phase.
REQ-026 Level SHALL hold in IDLE and SUSTAIN; SUSTAIN holds even if sustain_level changes.
REQ-027 Targets and rates SHALL be read live; a change takes effect at the next update or comparison.
REQ-028 done[v] SHALL be 1 for exactly the cycle after the RELEASE->IDLE edge.
REQ-029 busy[v] SHALL be a registered decode of state!=IDLE.
REQ-030 With rate=0 the level SHALL change every cycle, starting with the first cycle in the phase.
REQ-031 Latency: note_on sampled at edge n SHALL give state ATTACK after edge n, and the first level change at edge n+1+rate.
REQ-032 A phase whose level already equals its target on entry SHALL exit on the next edge without changing the level.
REQ-033 Voices SHALL share no state, so simultaneous events on different voices are independent.

Reset
REQ-034 On rst_b=0 every voice SHALL immediately enter IDLE with level 0 and counter 0, and busy=0, done=0, level_out=0.
REQ-035 Reset mid-phase SHALL discard all progress; on release no voice leaves IDLE without a fresh note_on.
REQ-036 No state SHALL power up undefined; all registers SHALL be covered by the asynchronous reset.

Structure
REQ-037 A shared package SHALL hold the one-hot state encodings (5-bit: IDLE=00001 ... RELEASE=10000) and the parameter defaults.
REQ-038 One sub-module, env_voice, SHALL implement a single voice and be instantiated VOICES times by a generate loop; the top only slices buses.

Verification
REQ-039 Attack: VOICES=4, step=1, rates 0, attack_level=4, sustain_level=2, note_on[0] pulse. Required: level_out[0] reads 1,2,3,4,3,2 on successive cycles, then holds 2 with busy[0]=1.
REQ-040 Clamp: step=3, attack_level=10, rate 0. Required: level 3,6,9,10, never 12.
REQ-041 Release and done: from sustain 2 with release_level=0, note_off[1] is asserted. Required: level 1,0, then state IDLE, done[1] high for exactly one cycle, busy[1]=0.
REQ-042 Retrigger and priority: note_on during RELEASE at level 5 gives ATTACK from 5. note_on with note_off together during DECAY gives RELEASE.
REQ-043 Rate divider: attack_rate=3. Required: level changes every 4th cycle, with the first change 4 cycles after entering ATTACK.
REQ-044 Reset and independence: rst_b is pulsed low mid-attack on voice 2 while voice 3 is in sustain. Required: all outputs 0 immediately. Also, a separate voice's note_on leaves the other voices unchanged.
